// File: rtl/qerv_rf_ram_init_if.sv
// RF RAM port bundle: write port, read port and one-cycle-latency read data.
// The master drives address/data/enables; the slave returns rdata.
interface qerv_rf_ram_init_if #(
  parameter int width = 8,
  parameter int aw    = 6
);
  logic [aw-1:0]    waddr;
  logic [width-1:0] wdata;
  logic             wen;
  logic [aw-1:0]    raddr;
  logic             ren;
  logic [width-1:0] rdata;

  modport master (
    output waddr, wdata, wen, raddr, ren,
    input  rdata
  );

  modport slave (
    input  waddr, wdata, wen, raddr, ren,
    output rdata
  );
endinterface

// File: rtl/qerv_rf_ram_init.sv
// Zeroes the RF RAM after every reset, then becomes a transparent pass-through.
// Define QERV_RF_RAM_INIT_VERIFY_EN to read every word back and flag nonzero data.
module qerv_rf_ram_init #(
  parameter int width = 8,
  parameter int aw    = 6,
  parameter int depth = 2**aw
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_busy,
  output logic                 o_init_err,
  qerv_rf_ram_init_if.slave    up,
  qerv_rf_ram_init_if.master   ram
);

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    VERIFY = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [aw-1:0]    LAST = aw'(depth - 1);
  localparam logic [width-1:0] ZERO = '0;

  state_t        state_q;
  logic [aw-1:0] cnt_q;
  logic [aw-1:0] cnt_d;
  logic          busy_q;

  // Terminal test uses LAST, so the counter never has to hold depth itself.
  assign cnt_d = cnt_q + aw'(1);

`ifdef QERV_RF_RAM_INIT_VERIFY_EN
  logic chk_q;
  logic rd_done_q;
  logic err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      busy_q    <= 1'b1;
      chk_q     <= 1'b0;
      rd_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      chk_q <= 1'b0;
      if (chk_q && (ram.rdata != ZERO))
        err_q <= 1'b1;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= VERIFY;
          end
        end
        VERIFY: begin
          // rd_done_q covers the extra cycle that compares the last read.
          if (!rd_done_q) begin
            chk_q <= 1'b1;
            cnt_q <= cnt_d;
            if (cnt_q == LAST)
              rd_done_q <= 1'b1;
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_init_err = err_q;
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_d;
          if (cnt_q == LAST) begin
            cnt_q   <= '0;
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_init_err = 1'b0;
`endif

  assign o_busy   = busy_q;
  assign up.rdata = ram.rdata;

  // RAM port mux: sweep drives the RAM until DONE, then upstream owns it combinationally.
  always_comb begin
    ram.waddr = cnt_q;
    ram.wdata = ZERO;
    ram.wen   = 1'b0;
    ram.raddr = cnt_q;
    ram.ren   = 1'b0;
    if (!i_rst) begin
      case (state_q)
        CLEAR: ram.wen = 1'b1;
`ifdef QERV_RF_RAM_INIT_VERIFY_EN
        VERIFY: ram.ren = !rd_done_q;
`endif
        DONE: begin
          ram.waddr = up.waddr;
          ram.wdata = up.wdata;
          ram.wen   = up.wen;
          ram.raddr = up.raddr;
          ram.ren   = up.ren;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qerv_rf_ram_init.sv
// Bench for qerv_rf_ram_init: behavioural RAM with one-cycle read latency,
// scoreboard queues for sweep addresses and pass-through read data.
module tb_qerv_rf_ram_init;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [0:63];
  bit         fault17 = 1'b0;

  logic [5:0] wq[$];
  logic [5:0] rq[$];
  logic [7:0] dq[$];

`ifdef QERV_RF_RAM_INIT_VERIFY_EN
  localparam int SWEEP_LEN = 129;
  localparam int SWEEP_REN = 64;
`else
  localparam int SWEEP_LEN = 64;
  localparam int SWEEP_REN = 0;
`endif

  qerv_rf_ram_init_if #(.width(8), .aw(6)) up_bus ();
  qerv_rf_ram_init_if #(.width(8), .aw(6)) ram_bus ();

  qerv_rf_ram_init #(.width(8), .aw(6), .depth(64)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .o_busy     (busy),
    .o_init_err (err),
    .up         (up_bus),
    .ram        (ram_bus)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 64; i++) mem[i] = 8'h5A;

  always @(posedge clk) begin
    if (ram_bus.wen) mem[ram_bus.waddr] <= ram_bus.wdata;
    if (ram_bus.ren)
      ram_bus.rdata <= (fault17 && ram_bus.raddr == 6'd17) ? 8'h01 : mem[ram_bus.raddr];
  end

  task automatic drive_up(input logic [5:0] wa, input logic [7:0] wd, input logic we,
                          input logic [5:0] ra, input logic re);
    up_bus.waddr = wa;
    up_bus.wdata = wd;
    up_bus.wen   = we;
    up_bus.raddr = ra;
    up_bus.ren   = re;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_up(6'd3, 8'hFF, 1'b1, 6'd3, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b1 || err !== 1'b0 || ram_bus.wen !== 1'b0 || ram_bus.ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: busy=%b err=%b wen=%b ren=%b, need 1 0 0 0",
               busy, err, ram_bus.wen, ram_bus.ren);
    end
  endtask

  // Releases reset and follows the sweep to its end; upstream writes 0xFF to addr 3 throughout.
  task automatic run_sweep(input string tag, input bit exp_err);
    int cyc;
    int nren;
    logic [5:0] ea;
    wq.delete();
    rq.delete();
    for (int i = 0; i < 64; i++) begin
      wq.push_back(6'(i));
      if (SWEEP_REN != 0) rq.push_back(6'(i));
    end
    drive_up(6'd3, 8'hFF, 1'b1, 6'd3, 1'b1);
    rst = 1'b0;
    #1;
    cyc  = 0;
    nren = 0;
    while (busy === 1'b1 && cyc < 400) begin
      if (ram_bus.wen === 1'b1) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_write: addr=%0d at cycle %0d, need no write", tag, ram_bus.waddr, cyc);
        end else begin
          ea = wq.pop_front();
          if (ram_bus.waddr !== ea || ram_bus.wdata !== 8'h00) begin
            errors++;
            $display("FAIL %s_clear_write: addr=%0d data=%0h, need addr=%0d data=0",
                     tag, ram_bus.waddr, ram_bus.wdata, ea);
          end
        end
      end
      if (ram_bus.ren === 1'b1) begin
        nren++;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL %s_extra_read: addr=%0d at cycle %0d, need no read", tag, ram_bus.raddr, cyc);
        end else begin
          ea = rq.pop_front();
          if (ram_bus.raddr !== ea) begin
            errors++;
            $display("FAIL %s_verify_read: addr=%0d, need %0d", tag, ram_bus.raddr, ea);
          end
        end
      end
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != SWEEP_LEN) begin
      errors++;
      $display("FAIL %s_busy_len: busy fell after %0d cycles, need %0d", tag, cyc, SWEEP_LEN);
    end
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL %s_writes_left: %0d addresses never written, need 0", tag, wq.size());
    end
    checks++;
    if (nren != SWEEP_REN) begin
      errors++;
      $display("FAIL %s_ren_count: %0d read cycles, need %0d", tag, nren, SWEEP_REN);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s_init_err: got %b, need %b", tag, err, exp_err);
    end
    drive_up(6'd0, 8'h00, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic test_clear();
    run_sweep("clear", 1'b0);
  endtask

  task automatic test_passthrough();
    logic [7:0] exp;
    drive_up(6'd5, 8'hA5, 1'b1, 6'd9, 1'b0);
    #1;
    checks++;
    if (ram_bus.waddr !== 6'd5 || ram_bus.wdata !== 8'hA5 || ram_bus.wen !== 1'b1 || ram_bus.ren !== 1'b0) begin
      errors++;
      $display("FAIL pass_write: waddr=%0d wdata=%0h wen=%b ren=%b, need 5 a5 1 0",
               ram_bus.waddr, ram_bus.wdata, ram_bus.wen, ram_bus.ren);
    end
    @(negedge clk);
    drive_up(6'd0, 8'h00, 1'b0, 6'd5, 1'b1);
    dq.push_back(8'hA5);
    #1;
    checks++;
    if (ram_bus.raddr !== 6'd5 || ram_bus.ren !== 1'b1 || ram_bus.wen !== 1'b0) begin
      errors++;
      $display("FAIL pass_read: raddr=%0d ren=%b wen=%b, need 5 1 0", ram_bus.raddr, ram_bus.ren, ram_bus.wen);
    end
    @(negedge clk);
    drive_up(6'd0, 8'h00, 1'b0, 6'd3, 1'b1);
    dq.push_back(8'h00);
    #1;
    exp = dq.pop_front();
    checks++;
    if (up_bus.rdata !== exp) begin
      errors++;
      $display("FAIL pass_rdata_a5: got %0h, need %0h", up_bus.rdata, exp);
    end
    @(negedge clk);
    drive_up(6'd0, 8'h00, 1'b0, 6'd0, 1'b0);
    #1;
    exp = dq.pop_front();
    checks++;
    if (up_bus.rdata !== exp) begin
      errors++;
      $display("FAIL dropped_write_addr3: read %0h, need %0h", up_bus.rdata, exp);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL done_busy: got %b, need 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 0;
    while (!(ram_bus.wen === 1'b1 && ram_bus.waddr == 6'd20) && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
    end
    checks++;
    if (cyc != 20) begin
      errors++;
      $display("FAIL mid_reach20: addr 20 written at cycle %0d, need 20", cyc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (ram_bus.wen !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst_gate: wen=%b busy=%b, need 0 1", ram_bus.wen, busy);
    end
    @(negedge clk);
    run_sweep("restart", 1'b0);
  endtask

`ifdef QERV_RF_RAM_INIT_VERIFY_EN
  task automatic test_verify_fault();
    int bad;
    fault17 = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    run_sweep("fault", 1'b1);
    bad = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (err !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fault_sticky: err dropped in %0d of 5 cycles, need 0", bad);
    end
    rst = 1'b1;
    fault17 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL fault_clear: err=%b after reset, need 0", err);
    end
    @(negedge clk);
    run_sweep("clean", 1'b0);
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive_up(6'd0, 8'h00, 1'b0, 6'd0, 1'b0);
    test_reset();
    test_clear();
    test_passthrough();
    test_reset_mid();
    test_passthrough();
`ifdef QERV_RF_RAM_INIT_VERIFY_EN
    test_verify_fault();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
